// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a downstream FIFO write port.
// Grants one word per cycle while the FIFO has room, holding a burst owner until last/limit/timeout.
module fifo_wr_arbiter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned BURST = 4,
   parameter int unsigned TMO   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         gnt,
   output logic                    wr_en,
   output logic [WIDTH-1:0]        buf_in,
   input  logic [3:0]              fifo_counter,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic                    burst_abort
);

   localparam int unsigned OW = $clog2(NREQ);
   localparam int unsigned BW = $clog2(BURST + 1);
   localparam int unsigned TW = $clog2(TMO + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [OW-1:0]   r_rr_ptr;
   logic [OW-1:0]   w_rr_ptr_nxt;
   logic [OW-1:0]   r_owner;
   logic [OW-1:0]   w_owner_nxt;
   logic [BW-1:0]   r_beat;
   logic [BW-1:0]   w_beat_nxt;
   logic [TW-1:0]   r_idle;
   logic [TW-1:0]   w_idle_nxt;
   logic            r_abort;
   logic            w_abort_nxt;
   logic            r_wr_en;
   logic [WIDTH-1:0] r_buf_in;

   logic [31:0]     w_fill;
   logic            w_accept_ok;
   logic            w_any;
   logic [OW-1:0]   w_winner;
   logic [OW-1:0]   w_scan;
   logic [OW-1:0]   w_sel;
   logic            w_cand;
   logic            w_accept;
   logic [WIDTH-1:0] w_data;

   // Modulo-NREQ increment, safe for non-power-of-two requester counts
   function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] p);
      return (32'(p) == NREQ - 1) ? '0 : OW'(32'(p) + 32'd1);
   endfunction

   // Room check counts the write already in flight
   always_comb begin
      w_fill      = 32'(fifo_counter) + 32'(r_wr_en);
      w_accept_ok = (w_fill < 32'(DEPTH - 1));
   end

   // First requester at or after rr_ptr
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      w_scan   = r_rr_ptr;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (!w_any && req[w_scan]) begin
            w_any    = 1'b1;
            w_winner = w_scan;
         end
         w_scan = wrap_inc(w_scan);
      end
   end

   // Next-state and grant logic
   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_owner_nxt  = r_owner;
      w_beat_nxt   = r_beat;
      w_idle_nxt   = r_idle;
      w_abort_nxt  = 1'b0;
      gnt          = '0;

      w_sel    = (r_state == S_IDLE) ? w_winner : r_owner;
      w_cand   = (r_state == S_IDLE) ? w_any : req[r_owner];
      w_accept = !rst && w_cand && w_accept_ok;
      w_data   = req_data[32'(w_sel) * WIDTH +: WIDTH];
      if (w_accept) begin
         gnt[w_sel] = 1'b1;
      end

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_owner_nxt = w_winner;
               w_beat_nxt  = BW'(1);
               w_idle_nxt  = '0;
               if (req_last[w_winner] || (BURST == 1)) begin
                  w_rr_ptr_nxt = wrap_inc(w_winner);
               end else begin
                  w_state_nxt = S_BURST;
               end
            end
         end
         S_BURST: begin
            if (req[r_owner]) begin
               // FIFO-full stalls keep the idle counter cleared
               w_idle_nxt = '0;
               if (w_accept) begin
                  w_beat_nxt = r_beat + BW'(1);
                  if (req_last[r_owner] || ((32'(r_beat) + 32'd1) >= BURST)) begin
                     w_state_nxt  = S_IDLE;
                     w_rr_ptr_nxt = wrap_inc(r_owner);
                  end
               end
            end else if ((32'(r_idle) + 32'd1) >= TMO) begin
               w_state_nxt  = S_IDLE;
               w_abort_nxt  = 1'b1;
               w_idle_nxt   = '0;
               w_rr_ptr_nxt = wrap_inc(r_owner);
            end else begin
               w_idle_nxt = r_idle + TW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_beat   <= '0;
         r_idle   <= '0;
         r_abort  <= 1'b0;
         r_wr_en  <= 1'b0;
         r_buf_in <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_owner  <= w_owner_nxt;
         r_beat   <= w_beat_nxt;
         r_idle   <= w_idle_nxt;
         r_abort  <= w_abort_nxt;
         r_wr_en  <= w_accept;
         if (w_accept) begin
            r_buf_in <= w_data;
         end
      end
   end

   assign wr_en       = r_wr_en;
   assign buf_in      = r_buf_in;
   assign owner       = r_owner;
   assign busy        = (r_state == S_BURST);
   assign burst_abort = r_abort;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 4, data word width; NREQ, default 4, number of requesters; DEPTH, default 8, depth of the downstream FIFO; BURST, default 4, maximum words per grant; TMO, default 8, idle-cycle limit inside a burst.
REQ-002 Ports SHALL be:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous, active-high reset
  req  in  NREQ  requester i has a valid word
  req_data  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
  req_last  in  NREQ  word of requester i ends its burst
  gnt  out  NREQ  one-hot or zero; word of requester i is accepted at this clock edge
  wr_en  out  1  registered FIFO write strobe
  buf_in  out  WIDTH  registered FIFO write data
  fifo_counter  in  4  FIFO occupancy
  owner  out  log2(NREQ)  current or last burst owner
  busy  out  1  high in BURST state
  burst_abort  out  1  one-cycle pulse when a burst is released by timeout
REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 Space rule: accept_ok = (fifo_counter + wr_en) < DEPTH-1; wr_en counts as an in-flight write. At most one word SHALL be accepted per cycle, and only when accept_ok is true.
REQ-005 gnt SHALL be combinational from the state, req, and accept_ok. The accepted word SHALL appear on buf_in with wr_en=1 exactly 1 cycle later. In a cycle with no acceptance, wr_en SHALL be 0 and buf_in SHALL hold its value.
REQ-006 FSM SHALL have 2 states: IDLE and BURST.
REQ-007 IDLE: the winner SHALL be the first requester with req=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ. If accept_ok is true, gnt[winner]=1.
REQ-008 When a word is accepted in IDLE:
  - owner SHALL be set to the winner and beat count to 1.
  - If req_last=1 or BURST=1: stay in IDLE and set rr_ptr to winner+1 mod NREQ.
  - Otherwise: go to BURST.
REQ-009 BURST: only owner SHALL be eligible. Each accepted word SHALL increment the beat count.
  - The burst SHALL end when a word with req_last=1 is accepted, or when the beat count reaches BURST (forced end, req_last ignored).
  - On end: go to IDLE and set rr_ptr to owner+1 mod NREQ.
REQ-010 BURST idle counter:
  - It SHALL count cycles in which req[owner]=0 and SHALL clear on any cycle with req[owner]=1.
  - When it reaches TMO: go to IDLE, pulse burst_abort for 1 cycle, set rr_ptr to owner+1.
  - A stall caused by accept_ok=0 SHALL NOT count toward the timeout.
REQ-011 Requests from non-owners during BURST SHALL receive gnt=0 and SHALL be served only after the burst ends.
REQ-012 rr_ptr arithmetic SHALL wrap: NREQ-1 plus 1 gives 0.
REQ-013 busy SHALL equal (state==BURST). owner SHALL hold its last value while in IDLE.

Reset
REQ-014 When rst=1 at a clock edge, the block SHALL go to IDLE with rr_ptr=0, owner=0, beat count 0, idle counter 0, wr_en=0, buf_in=0 and burst_abort=0.
REQ-015 gnt SHALL be 0 in any cycle with rst=1.
REQ-016 A reset during BURST SHALL discard the burst with no abort pulse. The first grant after reset SHALL follow the order starting from requester 0.

Verification
REQ-017 All requesters hold req=1 with req_last=1 and fifo_counter=0: grants SHALL go 0,1,2,3,0 on consecutive cycles, and wr_en=1 from the 2nd cycle onward.
REQ-018 Requester 1 sends a 3-word burst (last on word 3) while requester 2 also holds req: gnt[1] SHALL be high for 3 cycles with busy=1 for cycles 2-3, then gnt[2] SHALL be granted.
REQ-019 Requester 0 holds req=1 with req_last=0, BURST=4: the burst SHALL be forced to end after 4 words, and the next grant SHALL go to requester 1 if it is requesting.
REQ-020 fifo_counter=6, DEPTH=8, one requester active: 1 word SHALL be accepted. With fifo_counter still 6 and wr_en=1, gnt SHALL be 0; granting SHALL resume when fifo_counter+wr_en<7.
REQ-021 Owner 3 drops req mid-burst for 8 cycles: burst_abort SHALL pulse on the 8th cycle, busy SHALL fall, and the next grant SHALL go to requester 0.
REQ-022 rst asserted during the 2nd word of a burst: the next cycle SHALL have wr_en=0, buf_in=0, busy=0, and with all req=1 gnt SHALL go to requester 0.
